// File: rtl/seq_detect_ctrl_if.sv
`timescale 1ns/1ps
// Bus between a word-wide source and the serial pattern detection controller:
// config write, valid/ready word handshake and per-frame result reporting.
interface seq_detect_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
);
    logic              Cfg_We;
    logic [PAT_W-1:0]  Cfg_Pattern;
    logic              Cfg_Overlap;
    logic              In_Valid;
    logic [DATA_W-1:0] In_Data;
    logic              In_Last;
    logic              In_Ready;
    logic              Busy;
    logic              Match;
    logic [CNT_W-1:0]  Match_Cnt;
    logic              Cnt_Ovf;
    logic              Done;

    modport master (
        output Cfg_We, Cfg_Pattern, Cfg_Overlap, In_Valid, In_Data, In_Last,
        input  In_Ready, Busy, Match, Match_Cnt, Cnt_Ovf, Done
    );

    modport slave (
        input  Cfg_We, Cfg_Pattern, Cfg_Overlap, In_Valid, In_Data, In_Last,
        output In_Ready, Busy, Match, Match_Cnt, Cnt_Ovf, Done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
`timescale 1ns/1ps
// Frame controller: serialises handshaked words MSB-first into a programmable
// PAT_W-bit matcher, counts matches per frame and flags frame completion.
module seq_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    seq_detect_ctrl_if.slave bus
);
    localparam int BIDX_W = $clog2(DATA_W);
    localparam int HC_W   = $clog2(PAT_W + 1);
    // Default pattern 0111, keeping its leading bits when PAT_W < 4
    localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(32'd7 >> ((PAT_W >= 4) ? 0 : (4 - PAT_W)));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_sr;
    logic               r_last;
    logic [BIDX_W-1:0]  r_bit_idx;
    logic [PAT_W-2:0]   r_hist;
    logic [HC_W-1:0]    r_hist_cnt;
    logic [PAT_W-1:0]   r_pattern;
    logic               r_overlap;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_ready;
    logic               w_accept;
    logic               w_bit;
    logic               w_final;
    logic               w_hit;
    logic [PAT_W-1:0]   w_window;

    assign w_bit    = r_sr[DATA_W-1];
    assign w_window = {r_hist, w_bit};
    assign w_final  = (r_bit_idx == BIDX_W'(DATA_W - 1));
    assign w_accept = bus.In_Valid & w_ready;
    // Match needs PAT_W bits of valid history including the bit being consumed now
    assign w_hit    = (r_state == SHIFT) && (w_window == r_pattern) &&
                      (r_hist_cnt >= HC_W'(PAT_W - 1));

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.In_Valid) w_state_next = SHIFT;
            end
            SHIFT: begin
                w_ready = w_final & ~r_last;
                if (w_final) begin
                    if (r_last)            w_state_next = DONE;
                    else if (bus.In_Valid) w_state_next = SHIFT;
                    else                   w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_ready = 1'b1;
                if (bus.In_Valid) w_state_next = SHIFT;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_last     <= 1'b0;
            r_bit_idx  <= '0;
            r_hist     <= '0;
            r_hist_cnt <= '0;
            r_pattern  <= RST_PAT;
            r_overlap  <= 1'b1;
            r_match    <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_match <= w_hit;

            if (r_state == IDLE && bus.Cfg_We) begin
                r_pattern <= bus.Cfg_Pattern;
                r_overlap <= bus.Cfg_Overlap;
            end

            if (w_accept) begin
                r_sr      <= bus.In_Data;
                r_last    <= bus.In_Last;
                r_bit_idx <= '0;
            end else if (r_state == SHIFT) begin
                r_sr      <= {r_sr[DATA_W-2:0], 1'b0};
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // History survives WAIT and word reloads; only a new frame clears it
            if (w_accept && r_state == IDLE) begin
                r_hist     <= '0;
                r_hist_cnt <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_hist <= w_window[PAT_W-2:0];
                if (w_hit && !r_overlap)
                    r_hist_cnt <= '0;
                else if (r_hist_cnt != HC_W'(PAT_W))
                    r_hist_cnt <= r_hist_cnt + 1'b1;
                if (w_hit) begin
                    if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
                    else                  r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.In_Ready  = w_ready;
    assign bus.Busy      = (r_state != IDLE);
    assign bus.Match     = r_match;
    assign bus.Match_Cnt = r_cnt;
    assign bus.Cnt_Ovf   = r_ovf;
    assign bus.Done      = (r_state == DONE);
endmodule
